// File: rtl/poly_pw_pkg.sv
// Shared types and constants for the point-wise polynomial multiply sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package poly_pw_pkg;

  localparam int COEF_W     = 24;         // coefficient / modulus width
  localparam int M_W        = COEF_W + 1; // Barrett constant width
  localparam int N_W        = 5;          // bit length of q
  localparam int MM_LATENCY = 4;          // multiplier issue-to-result cycles

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } pw_state_e;

endpackage

// File: rtl/poly_pw_seq_if.sv
// Source-read, multiplier and destination-write signals of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: wr_ready from the destination; the multiplier side has none.
interface poly_pw_seq_if #(
  parameter int AW = 8
);
  import poly_pw_pkg::*;

  // source coefficient memories (shared strobe/address)
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [COEF_W-1:0] rd_a;
  logic [COEF_W-1:0] rd_b;
  // Barrett multiplier
  logic              mm_enable;
  logic [COEF_W-1:0] mm_a;
  logic [COEF_W-1:0] mm_b;
  logic [COEF_W-1:0] mm_q;
  logic [M_W-1:0]    mm_m;
  logic [N_W-1:0]    mm_n;
  logic              mm_valid;
  logic [COEF_W-1:0] mm_result;
  // destination memory
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [COEF_W-1:0] wr_data;
  logic              wr_ready;

  // master: the sequencer; slave: memories + multiplier around it
  modport master (
    output rd_en, rd_addr, mm_enable, mm_a, mm_b, mm_q, mm_m, mm_n,
           wr_en, wr_addr, wr_data,
    input  rd_a, rd_b, mm_valid, mm_result, wr_ready
  );
  modport slave (
    input  rd_en, rd_addr, mm_enable, mm_a, mm_b, mm_q, mm_m, mm_n,
           wr_en, wr_addr, wr_data,
    output rd_a, rd_b, mm_valid, mm_result, wr_ready
  );

endinterface

// File: rtl/poly_pw_fifo.sv
// Generic synchronous FIFO with occupancy count; pointers wrap modulo DEPTH.
// Latency: a push is visible at the head one cycle later.
// Backpressure: push ignored when full (unless popping), pop ignored when empty.
// Ports: clk/rst (sync, active-high), push/push_dat, pop/pop_dat (head), empty, full, count.
module poly_pw_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 8,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/poly_pw_seq.sv
// Point-wise a[i]*b[i] mod q sequencer around the fixed-latency Barrett multiplier.
// Latency: rd_en at t -> mm_enable t+1 -> mm_valid t+5 -> earliest wr_en t+6.
// Backpressure: credits cap reads in flight at FIFO_DEPTH, so a stalled wr_ready never loses a result.
// Ports: poly_pw_clk, poly_pw_rst (sync, active-high), start, cfg_q/m/n, busy, done,
//        bus (master): rd_* source reads, mm_* multiplier issue/result, wr_* destination writes.
module poly_pw_seq
  import poly_pw_pkg::*;
#(
  parameter int N_COEF     = 256,
  parameter int AW         = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              poly_pw_clk,
  input  logic              poly_pw_rst,
  input  logic              start,
  input  logic [COEF_W-1:0] cfg_q,
  input  logic [M_W-1:0]    cfg_m,
  input  logic [N_W-1:0]    cfg_n,
  output logic              busy,
  output logic              done,
  poly_pw_seq_if.master     bus
);

  localparam int CNT_W = $clog2(N_COEF + 1);
  localparam int CR_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_COEF);
  localparam logic [CR_W-1:0]  CR_MAX   = CR_W'(FIFO_DEPTH);

  // The FIFO must at least cover the results still inside the multiplier.
  if (FIFO_DEPTH < MM_LATENCY + 2) begin : g_depth_chk
    $error("poly_pw_seq: FIFO_DEPTH too small for the multiplier pipeline");
  end

  pw_state_e         state;
  pw_state_e         state_nxt;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  wr_cnt_nxt;
  logic [CR_W-1:0]   credit;
  logic              issue;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CR_W-1:0]   fifo_count;
  logic [COEF_W-1:0] fifo_head;
  logic              mm_en_q;
  logic [COEF_W-1:0] a_hold;
  logic [COEF_W-1:0] b_hold;

  assign issue      = (state == RUN) && (rd_cnt < LAST_CNT) && (credit < CR_MAX);
  assign pop        = !fifo_empty && bus.wr_ready;
  // Results still in flight after a reset come back while IDLE and are dropped.
  assign push       = bus.mm_valid && (state != IDLE);
  assign wr_cnt_nxt = wr_cnt + CNT_W'(pop);

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign bus.rd_en     = issue;
  assign bus.rd_addr   = AW'(rd_cnt);
  assign bus.mm_enable = mm_en_q;
  // Memory data arrives in the mm_enable cycle itself, so it is passed straight
  // through then and held afterwards.
  assign bus.mm_a      = mm_en_q ? bus.rd_a : a_hold;
  assign bus.mm_b      = mm_en_q ? bus.rd_b : b_hold;
  assign bus.wr_en     = !fifo_empty;
  assign bus.wr_addr   = AW'(wr_cnt);
  assign bus.wr_data   = fifo_empty ? '0 : fifo_head;

  poly_pw_fifo #(
    .W     (COEF_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (poly_pw_clk),
    .rst      (poly_pw_rst),
    .push     (push),
    .push_dat (bus.mm_result),
    .pop      (pop),
    .pop_dat  (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  // DRAIN looks at the post-pop count so DONE lands the cycle after the last write.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (rd_cnt == LAST_CNT) state_nxt = DRAIN;
      DRAIN:   if (wr_cnt_nxt == LAST_CNT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge poly_pw_clk) begin
    if (poly_pw_rst) begin
      state      <= IDLE;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      credit     <= '0;
      mm_en_q    <= 1'b0;
      a_hold     <= '0;
      b_hold     <= '0;
      bus.mm_q   <= '0;
      bus.mm_m   <= '0;
      bus.mm_n   <= '0;
    end else begin
      assert (fifo_count <= credit)
        else $error("poly_pw_seq: FIFO holds more results than reads outstanding");
      assert (!(push && fifo_full && !pop))
        else $error("poly_pw_seq: result pushed into a full FIFO");

      state   <= state_nxt;
      mm_en_q <= issue;
      if (mm_en_q) begin
        a_hold <= bus.rd_a;
        b_hold <= bus.rd_b;
      end
      if ((state == IDLE) && start) begin
        rd_cnt   <= '0;
        wr_cnt   <= '0;
        credit   <= '0;
        bus.mm_q <= cfg_q;
        bus.mm_m <= cfg_m;
        bus.mm_n <= cfg_n;
      end else begin
        if (issue) rd_cnt <= rd_cnt + 1'b1;
        wr_cnt <= wr_cnt_nxt;
        unique case ({issue, pop})
          2'b10:   credit <= credit + 1'b1;
          2'b01:   credit <= credit - 1'b1;
          default: credit <= credit;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_poly_pw_seq.sv
module tb_poly_pw_seq;
  import poly_pw_pkg::*;

  localparam int N = 256;
  localparam logic [23:0] Q = 24'd8380417;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] cfg_q = Q;
  logic [24:0] cfg_m = 25'd8396807;
  logic [4:0]  cfg_n = 5'd23;
  logic        busy;
  logic        done;

  poly_pw_seq_if #(.AW(8)) bus();

  poly_pw_seq #(.N_COEF(N), .AW(8), .FIFO_DEPTH(8)) dut (
    .poly_pw_clk (clk),
    .poly_pw_rst (rst),
    .start       (start),
    .cfg_q       (cfg_q),
    .cfg_m       (cfg_m),
    .cfg_n       (cfg_n),
    .busy        (busy),
    .done        (done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] modmul(logic [23:0] a, logic [23:0] b, logic [23:0] q);
    logic [47:0] p;
    if (q == '0) return '0;
    p = 48'(a) * 48'(b);
    return 24'(p % 48'(q));
  endfunction

  // ---- environment: source memories (1-cycle read) and 4-stage multiplier ----
  logic [23:0] mem_a [N];
  logic [23:0] mem_b [N];
  logic [3:0]  mv = '0;
  logic [23:0] mr [4];

  initial begin
    bus.rd_a = '0;
    bus.rd_b = '0;
    bus.wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) mr[i] = '0;
  end

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_a <= mem_a[bus.rd_addr];
      bus.rd_b <= mem_b[bus.rd_addr];
    end
    mv    <= {mv[2:0], bus.mm_enable};
    mr[0] <= modmul(bus.mm_a, bus.mm_b, bus.mm_q);
    mr[1] <= mr[0];
    mr[2] <= mr[1];
    mr[3] <= mr[2];
  end
  assign bus.mm_valid  = mv[3];
  assign bus.mm_result = mr[3];

  // ---- checking ----
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // job model: element i is read at address i, multiplied as a[i]*b[i] mod q,
  // and written in order to address i; at most 8 reads outstanding past the last write
  int          issued = 0, n_wr = 0, n_mm = 0, done_cnt = 0;
  int          t0 = 0, first_rd = -1, last_wr = -1, done_cyc = -1;
  logic [23:0] exp_d [N];
  logic [23:0] last_wr_data = '0;
  logic [23:0] lq = '0;
  logic [24:0] lm = '0;
  logic [4:0]  ln = '0;

  always @(negedge clk) begin
    if (rst) begin
      issued = 0; n_wr = 0; n_mm = 0;
    end else begin
      if (start && !busy) begin
        issued = 0; n_wr = 0; n_mm = 0; done_cnt = 0;
        t0 = cyc; first_rd = -1; last_wr = -1; done_cyc = -1;
        lq = cfg_q; lm = cfg_m; ln = cfg_n;
        for (int i = 0; i < N; i++) exp_d[i] = modmul(mem_a[i], mem_b[i], cfg_q);
      end
      if (bus.rd_en) begin
        if (issued == 0) first_rd = cyc - t0;
        chk("rd_addr", 64'(bus.rd_addr), 64'(issued % N));
        chk("credit_bound", 64'((issued - n_wr) < 8), 64'd1);
        issued++;
      end
      if (bus.mm_enable) begin
        chk("mm_a", 64'(bus.mm_a), 64'(mem_a[n_mm % N]));
        chk("mm_b", 64'(bus.mm_b), 64'(mem_b[n_mm % N]));
        chk("mm_cfg", 64'({bus.mm_q, bus.mm_m, bus.mm_n}), 64'({lq, lm, ln}));
        n_mm++;
      end
      if (bus.wr_en && bus.wr_ready) begin
        if (n_wr < N) begin
          chk("wr_addr", 64'(bus.wr_addr), 64'(n_wr));
          chk("wr_data", 64'(bus.wr_data), 64'(exp_d[n_wr]));
        end else begin
          chk("write_count", 64'(n_wr + 1), 64'(N));
        end
        last_wr = cyc - t0;
        last_wr_data = bus.wr_data;
        n_wr++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc - t0;
        chk("writes_at_done", 64'(n_wr), 64'(N));
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({busy, done, bus.rd_en, bus.rd_addr, bus.mm_enable,
                              bus.wr_en, bus.wr_addr}), 64'd0);
    chk({tag, "_ops"}, 64'({bus.mm_a, bus.mm_b}), 64'd0);
    chk({tag, "_cfg"}, 64'({bus.mm_q, bus.mm_m, bus.mm_n}), 64'd0);
    chk({tag, "_wr_data"}, 64'(bus.wr_data), 64'd0);
  endtask

  // mode 0: wr_ready high; 1: high one cycle in three; 2: low for cycles 120..169
  task automatic run_job(input int mode, input int rst_at, input bit poke);
    bit fin = 1'b0;
    @(posedge clk); #1;
    cfg_q = Q; cfg_m = 25'd8396807; cfg_n = 5'd23;
    bus.wr_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int rel = 1; rel < 3000 && !fin; rel++) begin
      case (mode)
        1:       bus.wr_ready = (rel % 3 == 0);
        2:       bus.wr_ready = !(rel >= 120 && rel < 170);
        default: bus.wr_ready = 1'b1;
      endcase
      start = poke && (rel == 50 || rel == 263);
      if (poke && rel == 50) cfg_q = 24'd7340033;  // must not be picked up
      if (mode == 2 && rel == 169) begin
        chk("stall_outstanding", 64'(issued - n_wr), 64'd8);
        chk("stall_rd_en", 64'(bus.rd_en), 64'd0);
        chk("stall_wr_en", 64'(bus.wr_en), 64'd1);
        chk("stall_wr_data", 64'(bus.wr_data), 64'(exp_d[n_wr]));
      end
      if (rst_at >= 0 && issued >= rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        check_outputs_zero("reset_mid");
        return;
      end
      @(posedge clk); #1;
      if (done_cnt != 0) fin = 1'b1;
    end
    start = 1'b0;
    bus.wr_ready = 1'b1;
    chk("done_seen", 64'(done_cnt), 64'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("busy_after", 64'(busy), 64'd0);
    chk("total_writes", 64'(n_wr), 64'(N));
    chk("total_reads", 64'(issued), 64'(N));
    chk("total_issues", 64'(n_mm), 64'(N));
  endtask

  initial begin
    // power-on reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_outputs_zero("reset");

    // basic run: a[i]=i, b[i]=2
    for (int i = 0; i < N; i++) begin
      mem_a[i] = 24'(i);
      mem_b[i] = 24'd2;
    end
    run_job(0, -1, 1'b0);
    chk("basic_first_rd_cycle", 64'(first_rd), 64'd1);
    chk("basic_last_wr_cycle", 64'(last_wr), 64'd262);
    chk("basic_done_cycle", 64'(done_cyc), 64'd263);
    chk("basic_last_data", 64'(last_wr_data), 64'd510);

    // modular wrap, with start pulses in RUN and DONE that must be ignored
    for (int i = 0; i < N; i++) begin
      mem_a[i] = 24'd8380416;
      mem_b[i] = 24'd8380416;
    end
    run_job(0, -1, 1'b1);
    chk("wrap_last_data", 64'(last_wr_data), 64'd1);
    chk("wrap_done_cycle", 64'(done_cyc), 64'd263);

    // backpressure 1-of-3, then a 50-cycle full stall
    for (int i = 0; i < N; i++) begin
      mem_a[i] = 24'(i * 1000 + 7);
      mem_b[i] = 24'(i + 3);
    end
    run_job(1, -1, 1'b0);
    chk("bp_last_data", 64'(last_wr_data), 64'd7128887);
    run_job(2, -1, 1'b0);
    chk("stall_last_data", 64'(last_wr_data), 64'd7128887);

    // reset at element 100, then a clean full run
    for (int i = 0; i < N; i++) begin
      mem_a[i] = 24'($urandom_range(0, 8380416));
      mem_b[i] = 24'($urandom_range(0, 8380416));
    end
    run_job(0, 100, 1'b0);
    repeat (10) @(posedge clk);
    run_job(0, -1, 1'b0);
    chk("after_reset_done_cycle", 64'(done_cyc), 64'd263);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
